// File: rtl/cpu_debug_pkg.sv
// Shared defaults and the command record for the debug command bridge.
// The record layout is {ir, data}; it is what one FIFO slot holds.
package cpu_debug_pkg;

  localparam int SR_W_DEF        = 38;
  localparam int IR_W_DEF        = 2;
  localparam int DEPTH_DEF       = 4;
  localparam int SYNC_STAGES_DEF = 2;

  typedef struct packed {
    logic [IR_W_DEF-1:0] ir;
    logic [SR_W_DEF-1:0] data;
  } cmd_rec_t;

  function automatic cmd_rec_t make_cmd(input logic [IR_W_DEF-1:0] ir,
                                        input logic [SR_W_DEF-1:0] data);
    cmd_rec_t rec;
    rec.ir   = ir;
    rec.data = data;
    return rec;
  endfunction

endpackage

// File: rtl/cpu_debug_sync.sv
// Multi-flop synchronizer for a single level crossing into the clk domain.
module cpu_debug_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_r;

  // Shift the asynchronous level through the synchronizer chain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chain_r <= '0;
    end else begin
      chain_r <= {chain_r[STAGES-2:0], d};
    end
  end

  assign q = chain_r[STAGES-1];

endmodule

// File: rtl/cpu_debug_cmd_bridge.sv
// Bridges JTAG update-DR/IR strobes into the clk domain: captures {ir, sr} into
// a small command FIFO and decodes popped commands into per-channel action pulses.
module cpu_debug_cmd_bridge
  import cpu_debug_pkg::*;
#(
  parameter int SR_W        = SR_W_DEF,
  parameter int IR_W        = IR_W_DEF,
  parameter int ACTION_BIT  = SR_W - 1,
  parameter int DEPTH       = DEPTH_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       vs_udr,
  input  logic                       vs_uir,
  input  logic [IR_W-1:0]            ir_in,
  input  logic [SR_W-1:0]            sr,
  input  logic                       cmd_ready,
  input  logic                       overflow_clr,
  output logic                       cmd_valid,
  output logic [IR_W-1:0]            cmd_ir,
  output logic [SR_W-1:0]            cmd_data,
  output logic [SR_W-1:0]            jdo,
  output logic [(1<<IR_W)-1:0]       take_action,
  output logic [(1<<IR_W)-1:0]       take_no_action,
  output logic                       ir_update,
  output logic                       overflow,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int NUM_CH = 1 << IR_W;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam int GATE_N = SYNC_STAGES + 1;
  localparam int GATE_W = $clog2(GATE_N + 1);

  typedef struct packed {
    logic [IR_W-1:0] ir;
    logic [SR_W-1:0] data;
  } cmd_t;

  logic              udr_sync_s;
  logic              uir_sync_s;
  logic              udr_prev_r;
  logic              uir_prev_r;
  logic [GATE_W-1:0] gate_cnt_r;
  logic              gate_open_s;
  logic              udr_rise_s;
  logic              uir_rise_s;

  cmd_t              mem_r [DEPTH];
  cmd_t              head_s;
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [LVL_W-1:0]  level_r;
  logic [LVL_W-1:0]  level_nxt_s;
  logic              empty_s;
  logic              full_s;
  logic              push_s;
  logic              pop_s;
  logic              ovf_set_s;

  logic [SR_W-1:0]   jdo_r;
  logic [NUM_CH-1:0] ch_onehot_s;
  logic [NUM_CH-1:0] ta_nxt_s;
  logic [NUM_CH-1:0] tna_nxt_s;
  logic [NUM_CH-1:0] take_action_r;
  logic [NUM_CH-1:0] take_no_action_r;
  logic              ir_update_r;
  logic              overflow_r;

  cpu_debug_sync #(.STAGES(SYNC_STAGES)) u_sync_udr (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (vs_udr),
    .q       (udr_sync_s)
  );

  cpu_debug_sync #(.STAGES(SYNC_STAGES)) u_sync_uir (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (vs_uir),
    .q       (uir_sync_s)
  );

  // Previous-value flops for edge detection on the synchronized strobes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      udr_prev_r <= 1'b0;
      uir_prev_r <= 1'b0;
    end else begin
      udr_prev_r <= udr_sync_s;
      uir_prev_r <= uir_sync_s;
    end
  end

  // Blind window after reset so a strobe already high is not seen as a rise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gate_cnt_r <= '0;
    end else if (!gate_open_s) begin
      gate_cnt_r <= gate_cnt_r + GATE_W'(1);
    end else begin
      gate_cnt_r <= gate_cnt_r;
    end
  end

  // Rise detection, FIFO handshake and occupancy bookkeeping.
  always_comb begin
    gate_open_s = (gate_cnt_r == GATE_W'(GATE_N));
    udr_rise_s  = udr_sync_s & ~udr_prev_r & gate_open_s;
    uir_rise_s  = uir_sync_s & ~uir_prev_r & gate_open_s;
    empty_s     = (level_r == LVL_W'(0));
    full_s      = (level_r == LVL_W'(DEPTH));
    head_s      = mem_r[rd_ptr_r];
    pop_s       = ~empty_s & cmd_ready;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    push_s      = udr_rise_s & (~full_s | pop_s);
    ovf_set_s   = udr_rise_s & full_s & ~pop_s;
    case ({push_s, pop_s})
      2'b10:   level_nxt_s = level_r + LVL_W'(1);
      2'b01:   level_nxt_s = level_r - LVL_W'(1);
      default: level_nxt_s = level_r;
    endcase
    ch_onehot_s = NUM_CH'(1) << head_s.ir;
    if (pop_s) begin
      ta_nxt_s  = head_s.data[ACTION_BIT] ? ch_onehot_s : '0;
      tna_nxt_s = head_s.data[ACTION_BIT] ? '0 : ch_onehot_s;
    end else begin
      ta_nxt_s  = '0;
      tna_nxt_s = '0;
    end
  end

  // Command storage; contents are don't-care once the pointers are cleared.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= cmd_t'({ir_in, sr});
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
    end else begin
      wr_ptr_r <= push_s ? wr_ptr_r + PTR_W'(1) : wr_ptr_r;
      rd_ptr_r <= pop_s  ? rd_ptr_r + PTR_W'(1) : rd_ptr_r;
      level_r  <= level_nxt_s;
    end
  end

  // Registered results of a pop, IR-update pulse and sticky overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      jdo_r            <= '0;
      take_action_r    <= '0;
      take_no_action_r <= '0;
      ir_update_r      <= 1'b0;
      overflow_r       <= 1'b0;
    end else begin
      jdo_r            <= pop_s ? head_s.data : jdo_r;
      take_action_r    <= ta_nxt_s;
      take_no_action_r <= tna_nxt_s;
      ir_update_r      <= uir_rise_s;
      // A new drop wins over a clear arriving in the same cycle.
      if (ovf_set_s) begin
        overflow_r <= 1'b1;
      end else if (overflow_clr) begin
        overflow_r <= 1'b0;
      end else begin
        overflow_r <= overflow_r;
      end
    end
  end

  assign cmd_valid      = ~empty_s;
  assign cmd_ir         = head_s.ir;
  assign cmd_data       = head_s.data;
  assign jdo            = jdo_r;
  assign take_action    = take_action_r;
  assign take_no_action = take_no_action_r;
  assign ir_update      = ir_update_r;
  assign overflow       = overflow_r;
  assign level          = level_r;

endmodule

// File: tb/tb_cpu_debug_cmd_bridge.sv
// Directed bench for cpu_debug_cmd_bridge with hand-computed expectations.
module tb_cpu_debug_cmd_bridge;
  import cpu_debug_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        vs_udr;
  logic        vs_uir;
  logic [1:0]  ir_in;
  logic [37:0] sr;
  logic        cmd_ready;
  logic        overflow_clr;
  logic        cmd_valid;
  logic [1:0]  cmd_ir;
  logic [37:0] cmd_data;
  logic [37:0] jdo;
  logic [3:0]  take_action;
  logic [3:0]  take_no_action;
  logic        ir_update;
  logic        overflow;
  logic [2:0]  level;

  int n_cmp = 0;
  int n_bad = 0;

  cpu_debug_cmd_bridge dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .vs_udr         (vs_udr),
    .vs_uir         (vs_uir),
    .ir_in          (ir_in),
    .sr             (sr),
    .cmd_ready      (cmd_ready),
    .overflow_clr   (overflow_clr),
    .cmd_valid      (cmd_valid),
    .cmd_ir         (cmd_ir),
    .cmd_data       (cmd_data),
    .jdo            (jdo),
    .take_action    (take_action),
    .take_no_action (take_no_action),
    .ir_update      (ir_update),
    .overflow       (overflow),
    .level          (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic capture(input logic [1:0] ir, input logic [37:0] data);
    ir_in  = ir;
    sr     = data;
    vs_udr = 1'b1;
    tick(4);
    vs_udr = 1'b0;
    tick(3);
  endtask

  task automatic pop_one();
    cmd_ready = 1'b1;
    tick(1);
    cmd_ready = 1'b0;
  endtask

  logic [37:0] d_vec [5];
  logic [37:0] e_vec [5];
  logic [3:0]  exp_ta;
  int          upd_cnt;
  cmd_rec_t    rec;

  initial begin
    d_vec[0] = 38'h20_0000_0001;
    d_vec[1] = 38'h00_1234_5678;
    d_vec[2] = 38'h3F_FFFF_FFFF;
    d_vec[3] = 38'h00_0000_0000;
    d_vec[4] = 38'h2A_AAAA_AAAA;
    e_vec[0] = 38'h00_0000_0011;
    e_vec[1] = 38'h20_0000_0022;
    e_vec[2] = 38'h00_0000_0033;
    e_vec[3] = 38'h20_0000_0044;
    e_vec[4] = 38'h00_0000_0055;

    reset_n = 1'b0; vs_udr = 1'b0; vs_uir = 1'b0; ir_in = 2'd0; sr = 38'h0;
    cmd_ready = 1'b0; overflow_clr = 1'b0;
    tick(2);
    check_eq("rst_cmd_valid", 64'(cmd_valid), 64'd0);
    check_eq("rst_level", 64'(level), 64'd0);
    check_eq("rst_jdo", 64'(jdo), 64'd0);
    check_eq("rst_overflow", 64'(overflow), 64'd0);
    check_eq("rst_take_action", 64'(take_action), 64'd0);
    check_eq("rst_take_no_action", 64'(take_no_action), 64'd0);
    check_eq("rst_ir_update", 64'(ir_update), 64'd0);
    reset_n = 1'b1;
    tick(5);

    // Single capture: latency, head contents, then pop decode.
    rec = make_cmd(2'd2, 38'h20_0000_0015);
    ir_in = rec.ir; sr = rec.data; vs_udr = 1'b1;
    tick(1);
    check_eq("lat_edge1", 64'(cmd_valid), 64'd0);
    tick(1);
    check_eq("lat_edge2", 64'(cmd_valid), 64'd0);
    tick(1);
    check_eq("lat_edge3", 64'(cmd_valid), 64'd1);
    check_eq("t1_cmd_ir", 64'(cmd_ir), 64'd2);
    check_eq("t1_cmd_data", 64'(cmd_data), 64'h20_0000_0015);
    tick(1);
    vs_udr = 1'b0;
    tick(3);
    check_eq("t1_single_write", 64'(level), 64'd1);
    pop_one();
    check_eq("t1_take_action", 64'(take_action), 64'b0100);
    check_eq("t1_take_no_action", 64'(take_no_action), 64'd0);
    check_eq("t1_jdo", 64'(jdo), 64'h20_0000_0015);
    check_eq("t1_empty", 64'(cmd_valid), 64'd0);
    tick(1);
    check_eq("t1_pulse_end", 64'(take_action), 64'd0);
    check_eq("t1_jdo_held", 64'(jdo), 64'h20_0000_0015);

    // Fill to DEPTH, then a fifth capture collides with overflow_clr.
    for (int i = 0; i < 4; i++) capture(2'(i), d_vec[i]);
    check_eq("t2_full_level", 64'(level), 64'd4);
    check_eq("t2_no_ovf_yet", 64'(overflow), 64'd0);
    ir_in = 2'd0; sr = d_vec[4]; vs_udr = 1'b1;
    tick(2);
    overflow_clr = 1'b1;
    tick(1);
    overflow_clr = 1'b0;
    check_eq("t2_ovf_wins_clr", 64'(overflow), 64'd1);
    check_eq("t2_drop_level", 64'(level), 64'd4);
    tick(1);
    vs_udr = 1'b0;
    tick(3);
    check_eq("t2_ovf_sticky", 64'(overflow), 64'd1);
    for (int i = 0; i < 4; i++) begin
      check_eq("t2_head_data", 64'(cmd_data), 64'(d_vec[i]));
      check_eq("t2_head_ir", 64'(cmd_ir), 64'(i));
      pop_one();
      check_eq("t2_jdo", 64'(jdo), 64'(d_vec[i]));
      exp_ta = d_vec[i][37] ? (4'b0001 << i) : 4'b0000;
      check_eq("t2_take_action", 64'(take_action), 64'(exp_ta));
      check_eq("t2_take_no_action", 64'(take_no_action), 64'(exp_ta ^ (4'b0001 << i)));
    end
    check_eq("t2_drained", 64'(cmd_valid), 64'd0);
    overflow_clr = 1'b1;
    tick(1);
    overflow_clr = 1'b0;
    check_eq("t2_ovf_cleared", 64'(overflow), 64'd0);

    // Full FIFO with simultaneous capture and pop.
    for (int i = 0; i < 4; i++) capture(2'd3, e_vec[i]);
    ir_in = 2'd1; sr = e_vec[4]; vs_udr = 1'b1;
    tick(2);
    cmd_ready = 1'b1;
    tick(1);
    cmd_ready = 1'b0;
    check_eq("t3_level_kept", 64'(level), 64'd4);
    check_eq("t3_no_ovf", 64'(overflow), 64'd0);
    check_eq("t3_jdo", 64'(jdo), 64'(e_vec[0]));
    tick(1);
    vs_udr = 1'b0;
    tick(3);
    for (int i = 1; i < 5; i++) begin
      check_eq("t3_order_data", 64'(cmd_data), 64'(e_vec[i]));
      check_eq("t3_order_ir", 64'(cmd_ir), (i == 4) ? 64'd1 : 64'd3);
      pop_one();
    end
    check_eq("t3_drained", 64'(level), 64'd0);

    // Action bit clear selects take_no_action.
    capture(2'd1, 38'h00_0000_002A);
    pop_one();
    check_eq("t4_take_no_action", 64'(take_no_action), 64'b0010);
    check_eq("t4_take_action", 64'(take_action), 64'd0);

    // Coincident update-IR and update-DR strobes.
    ir_in = 2'd0; sr = 38'h00_0000_0015; vs_udr = 1'b1; vs_uir = 1'b1;
    upd_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (ir_update) upd_cnt++;
      if (i == 3) begin
        vs_udr = 1'b0;
        vs_uir = 1'b0;
      end
    end
    check_eq("t5_ir_update_count", 64'(upd_cnt), 64'd1);
    check_eq("t5_one_write", 64'(level), 64'd1);
    pop_one();

    // Strobe held high across reset release creates no command.
    vs_udr = 1'b1;
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(6);
    vs_udr = 1'b0;
    tick(3);
    check_eq("t6_no_cmd_valid", 64'(cmd_valid), 64'd0);
    check_eq("t6_no_cmd_level", 64'(level), 64'd0);

    // Reset mid-operation with queued commands clears immediately.
    for (int i = 0; i < 4; i++) capture(2'(i), e_vec[i]);
    pop_one();
    check_eq("t6_queued", 64'(level), 64'd3);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check_eq("t6_async_valid", 64'(cmd_valid), 64'd0);
    check_eq("t6_async_level", 64'(level), 64'd0);
    check_eq("t6_async_jdo", 64'(jdo), 64'd0);
    tick(2);
    reset_n = 1'b1;
    tick(5);
    capture(2'd2, 38'h00_0000_0077);
    check_eq("t6_after_reset_data", 64'(cmd_data), 64'h77);
    check_eq("t6_after_reset_level", 64'(level), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
